// File: rtl/dralm_acc.sv
// dralm_acc: streaming accumulator for the signed products of the DRALM
// 16x16 log multiplier. Each job sums a programmed number of 32-bit products
// into an ACC_W-bit two's-complement accumulator. The result is returned over
// a valid/ready handshake.
//
// Optional feature macro: DRALM_ACC_SAT_EN
//   defined   -> on overflow the accumulator clamps to the signed max/min
//   undefined -> on overflow the accumulator wraps modulo 2^ACC_W
// In both builds the sticky out_ovf flag is set when an add overflows.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          job request and product count (sampled in IDLE only)
//   in_valid, in_ready  product beat handshake (in_ready depends only on state)
//   in_p                signed 32-bit product
//   out_valid, out_ready result handshake
//   out_sum, out_ovf    accumulated result and sticky overflow flag
//   busy                high whenever the FSM is not in IDLE
module dralm_acc #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_step;
  logic             step_ovf;

  // Sign-extend the product and detect signed overflow of the add.
  assign p_ext    = {{(ACC_W-32){in_p[31]}}, in_p};
  assign sum_raw  = acc + p_ext;
  assign step_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                    (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef DRALM_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp toward the sign shared by both operands.
  assign sum_step = step_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign sum_step = sum_raw;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    rem_nxt   = rem;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          rem_nxt   = len;
          state_nxt = (len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_nxt = sum_step;
          ovf_nxt = ovf | step_ovf;
          rem_nxt = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      rem       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      ovf       <= ovf_nxt;
      rem       <= rem_nxt;
      in_ready  <= (state_nxt == S_ACC);
      out_valid <= (state_nxt == S_DONE);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_dralm_acc.sv
// Directed self-checking bench for dralm_acc. A 40-bit instance covers the
// normal job flows; a 33-bit instance covers overflow (wrap or saturate
// depending on DRALM_ACC_SAT_EN).
module tb_dralm_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_p = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_sum;
  logic        out_ovf;
  logic        busy;

  logic        s_start = 1'b0;
  logic [7:0]  s_len = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_p = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [32:0] s_out_sum;
  logic        s_out_ovf;
  logic        s_busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dralm_acc #(.ACC_W(40), .LEN_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  dralm_acc #(.ACC_W(33), .LEN_W(8)) u_dut33 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .len(s_len),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_p(s_in_p),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] exp40;
    logic [32:0] exp33;
    logic signed [15:0] x, y;
    logic signed [31:0] prod;
    logic signed [39:0] model;

    // Reset state
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Job 1: len=4, 100 -50 7 3 back-to-back
    out_ready = 1'b1;
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    chk("j1_in_ready", 64'(in_ready), 64'd1);
    chk("j1_busy", 64'(busy), 64'd1);
    in_valid = 1'b1; in_p = 32'd100;
    tick(); in_p = -32'sd50;
    tick(); in_p = 32'd7;
    tick(); in_p = 32'd3;
    chk("j1_no_early_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("j1_out_valid", 64'(out_valid), 64'd1);
    chk("j1_out_sum", 64'(out_sum), 64'd60);
    chk("j1_out_ovf", 64'(out_ovf), 64'd0);
    chk("j1_in_ready_done", 64'(in_ready), 64'd0);
    tick();
    chk("j1_valid_one_cycle", 64'(out_valid), 64'd0);
    chk("j1_idle_busy", 64'(busy), 64'd0);

    // Job 2: len=0 goes straight to DONE
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk("j2_out_valid", 64'(out_valid), 64'd1);
    chk("j2_in_ready", 64'(in_ready), 64'd0);
    chk("j2_out_sum", 64'(out_sum), 64'd0);
    tick();
    chk("j2_idle", 64'(out_valid), 64'd0);
    chk("j2_in_ready_after", 64'(in_ready), 64'd0);

    // Job 3: len=3 with gaps, then result stall with an ignored start
    out_ready = 1'b0;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_p = 32'd10;
    tick(); in_valid = 1'b0;
    tick();
    tick(); in_valid = 1'b1; in_p = 32'd20;
    tick(); in_valid = 1'b0;
    chk("j3_stall_in_ready", 64'(in_ready), 64'd1);
    chk("j3_stall_no_valid", 64'(out_valid), 64'd0);
    tick(); in_valid = 1'b1; in_p = 32'd30;
    tick(); in_valid = 1'b0;
    chk("j3_out_valid", 64'(out_valid), 64'd1);
    chk("j3_out_sum", 64'(out_sum), 64'd60);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 8'd5;
      tick();
      chk("j3_hold_valid", 64'(out_valid), 64'd1);
      chk("j3_hold_sum", 64'(out_sum), 64'd60);
      chk("j3_hold_busy", 64'(busy), 64'd1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("j3_released", 64'(out_valid), 64'd0);
    chk("j3_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("j3_start_not_queued", 64'(busy), 64'd0);

    // Overflow on the 33-bit instance: three beats of 0x7FFFFFFF
`ifdef DRALM_ACC_SAT_EN
    exp33 = 33'h0FFFFFFFF;
`else
    exp33 = 33'h17FFFFFFD;
`endif
    s_start = 1'b1; s_len = 8'd3;
    tick();
    s_start = 1'b0;
    s_in_valid = 1'b1; s_in_p = 32'h7FFFFFFF;
    tick();
    tick();
    chk("ovf_not_yet", 64'(s_out_ovf), 64'd0);
    tick();
    s_in_valid = 1'b0;
    chk("ovf_out_valid", 64'(s_out_valid), 64'd1);
    chk("ovf_flag", 64'(s_out_ovf), 64'd1);
    chk("ovf_sum", 64'(s_out_sum), 64'(exp33));
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    chk("ovf_idle", 64'(s_busy), 64'd0);

    // Async reset mid-job, then a fresh len=1 job
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_p = 32'd1000;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_sum", 64'(out_sum), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_p = -32'sd7;
    tick();
    in_valid = 1'b0;
    exp40 = -40'sd7;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_sum", 64'(out_sum), 64'(exp40));
    chk("post_rst_ovf", 64'(out_ovf), 64'd0);
    tick();

    // len=255 with random signed 16x16 products
    model = '0;
    start = 1'b1; len = 8'd255;
    tick();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      prod = 32'(x) * 32'(y);
      model = model + 40'(prod);
      in_valid = 1'b1; in_p = prod;
      if (i == 254) chk("rnd_no_early_valid", 64'(out_valid), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("rnd_out_valid", 64'(out_valid), 64'd1);
    chk("rnd_out_sum", 64'(out_sum), 64'(model));
    chk("rnd_out_ovf", 64'(out_ovf), 64'd0);
    tick();
    chk("rnd_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
